// File: rtl/alu_ctrl_branch_unit.sv
// ---------------------------------------------------------------------------
// alu_ctrl_branch_unit
//
// Purpose:
//   Decodes the ID-stage instruction into ALU operation and datapath controls,
//   carries them into EX through an ID/EX control register (with stall and
//   flush), and resolves branches/jumps in EX from the ALU Zero flag.
//
// Ports:
//   clk, rst_n   core clock (rising edge) / asynchronous active-low reset
//   InstrD       ID-stage instruction ([6:0] opcode, [14:12] funct3, [30] funct7b5)
//   StallE       hold the EX control register
//   FlushE       load a bubble into the EX control register
//   ZeroE        ALU Zero flag of the instruction in EX
//   ImmSrcD      combinational immediate-format select for the ID immediate gen
//   IllegalD     combinational, ID instruction is unsupported
//   ALUOpE       registered ALU op (add 000, sub 001, and 010, or 011, slt 100, xor 110)
//   ALUSrcE      registered, 1 selects the immediate as ALU B
//   RegWriteE    registered register-file write enable
//   MemWriteE    registered data-memory write enable
//   ResultSrcE   registered writeback select (00 ALU, 01 memory, 10 PC+4)
//   PCSrcE       combinational redirect of the PC to the branch/jump target
//   FlushD       equals PCSrcE, flushes the IF/ID register
//
// RESET_BUBBLE must be 1: reset always loads a bubble (all EX controls 0).
// ---------------------------------------------------------------------------
module alu_ctrl_branch_unit #(
    parameter int RESET_BUBBLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstrD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic        ZeroE,
    output logic [2:0]  ImmSrcD,
    output logic        IllegalD,
    output logic [2:0]  ALUOpE,
    output logic        ALUSrcE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic [1:0]  ResultSrcE,
    output logic        PCSrcE,
    output logic        FlushD
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b110;

    // Only the bubble reset value is supported; the parameter is kept for
    // interface compatibility.
    localparam bit unused_reset_bubble = (RESET_BUBBLE != 0);

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic       jump;
        logic [1:0] br_type;   // {funct3[2], funct3[0]}: beq 00, bne 01, blt 10, bge 11
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE = '0;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr_bits;

    assign opcode            = InstrD[6:0];
    assign funct3            = InstrD[14:12];
    assign funct7b5          = InstrD[30];
    assign unused_instr_bits = ^{InstrD[31], InstrD[29:15], InstrD[11:7]};

    // Shared funct3 -> ALU op map for R-type and I-ALU. funct3 000 is add here;
    // the R-type decode overrides it with sub when funct7b5 is set.
    logic [2:0] arith_op;
    logic       arith_ok;

    always_comb begin
        arith_op = ALU_ADD;
        arith_ok = 1'b1;
        case (funct3)
            3'b000:  arith_op = ALU_ADD;
            3'b111:  arith_op = ALU_AND;
            3'b110:  arith_op = ALU_OR;
            3'b010:  arith_op = ALU_SLT;
            3'b100:  arith_op = ALU_XOR;
            default: arith_ok = 1'b0;
        endcase
    end

    ex_ctrl_t dec_ctrl;
    logic     dec_illegal;
    logic [2:0] dec_imm_src;

    always_comb begin
        dec_ctrl    = BUBBLE;
        dec_illegal = 1'b0;
        dec_imm_src = 3'b000;
        case (opcode)
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : arith_op;
                dec_illegal        = !arith_ok;
            end
            OP_I: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = arith_op;
                dec_illegal        = !arith_ok;
            end
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = 2'b01;
                dec_illegal         = (funct3 != 3'b010);
            end
            OP_STORE: begin
                dec_imm_src        = 3'b001;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_illegal        = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                dec_imm_src      = 3'b010;
                dec_ctrl.branch  = 1'b1;
                dec_ctrl.br_type = {funct3[2], funct3[0]};
                case (funct3)
                    3'b000, 3'b001: dec_ctrl.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec_ctrl.alu_op = ALU_SLT;
                    default:        dec_illegal     = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec_imm_src         = 3'b011;
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = 2'b10;
            end
            default: dec_illegal = 1'b1;
        endcase
        // An unsupported instruction travels down the pipe as a harmless add
        // with no side effects.
        if (dec_illegal) begin
            dec_ctrl = BUBBLE;
        end
    end

    assign ImmSrcD  = dec_imm_src;
    assign IllegalD = dec_illegal;

    // ------------------------------------------------------------------ EX
    ex_ctrl_t ex_ctrl_d;
    ex_ctrl_t ex_ctrl_q;
    logic     br_taken;
    logic     pc_src;

    // beq/bge are taken on Zero, bne/blt on !Zero (slt leaves 0 when a >= b).
    assign br_taken = ZeroE ^ (ex_ctrl_q.br_type[1] ^ ex_ctrl_q.br_type[0]);
    assign pc_src   = ex_ctrl_q.jump | (ex_ctrl_q.branch & br_taken);

    // A redirect kills the instruction in ID on the same edge, so it wins
    // over a stall just like an external flush does.
    always_comb begin
        ex_ctrl_d = dec_ctrl;
        if (FlushE || pc_src) begin
            ex_ctrl_d = BUBBLE;
        end else if (StallE) begin
            ex_ctrl_d = ex_ctrl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q <= BUBBLE;
        end else begin
            ex_ctrl_q <= ex_ctrl_d;
        end
    end

    assign ALUOpE     = ex_ctrl_q.alu_op;
    assign ALUSrcE    = ex_ctrl_q.alu_src;
    assign RegWriteE  = ex_ctrl_q.reg_write;
    assign MemWriteE  = ex_ctrl_q.mem_write;
    assign ResultSrcE = ex_ctrl_q.result_src;
    assign PCSrcE     = pc_src;
    assign FlushD     = pc_src;

endmodule

// File: tb/tb_alu_ctrl_branch_unit.sv
module tb_alu_ctrl_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] InstrD;
    logic        StallE;
    logic        FlushE;
    logic        ZeroE;
    logic [2:0]  ImmSrcD;
    logic        IllegalD;
    logic [2:0]  ALUOpE;
    logic        ALUSrcE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE;
    logic        FlushD;

    alu_ctrl_branch_unit #(.RESET_BUBBLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstrD     (InstrD),
        .StallE     (StallE),
        .FlushE     (FlushE),
        .ZeroE      (ZeroE),
        .ImmSrcD    (ImmSrcD),
        .IllegalD   (IllegalD),
        .ALUOpE     (ALUOpE),
        .ALUSrcE    (ALUSrcE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .FlushD     (FlushD)
    );

    // ---------------------------------------------------------- clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------ scoreboard
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {ALUOpE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE}
    function automatic logic [7:0] e_ctrl();
        return {ALUOpE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE};
    endfunction

    // --------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic stall,
                         input logic flush, input logic zero);
        InstrD = instr;
        StallE = stall;
        FlushE = flush;
        ZeroE  = zero;
        #1;
    endtask

    // Instruction encodings
    localparam logic [31:0] I_SUB   = 32'h40B50533;
    localparam logic [31:0] I_XOR   = 32'h00B54533;
    localparam logic [31:0] I_ADD   = 32'h00B50533;
    localparam logic [31:0] I_OR    = 32'h00B56533;
    localparam logic [31:0] I_AND   = 32'h00B57533;
    localparam logic [31:0] I_SLT   = 32'h00B52533;
    localparam logic [31:0] I_ADDI  = 32'h00550513;
    localparam logic [31:0] I_ADDIB = 32'h40050513;
    localparam logic [31:0] I_LW    = 32'h0005A503;
    localparam logic [31:0] I_SW    = 32'h00A5A023;
    localparam logic [31:0] I_LB    = 32'h00058503;
    localparam logic [31:0] I_BEQ   = 32'h00B50463;
    localparam logic [31:0] I_BNE   = 32'h00B51463;
    localparam logic [31:0] I_BLT   = 32'h00B54463;
    localparam logic [31:0] I_BGE   = 32'h00B55463;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_ILL   = 32'h0000707F;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  exp_e;
        logic [2:0]  exp_imm;
        logic        exp_ill;
    } vec_t;

    vec_t sweep[11];

    initial begin
        sweep[0]  = '{I_SUB,   8'h28, 3'b000, 1'b0};
        sweep[1]  = '{I_XOR,   8'hC8, 3'b000, 1'b0};
        sweep[2]  = '{I_ADD,   8'h08, 3'b000, 1'b0};
        sweep[3]  = '{I_OR,    8'h68, 3'b000, 1'b0};
        sweep[4]  = '{I_AND,   8'h48, 3'b000, 1'b0};
        sweep[5]  = '{I_SLT,   8'h88, 3'b000, 1'b0};
        sweep[6]  = '{I_ADDI,  8'h18, 3'b000, 1'b0};
        sweep[7]  = '{I_ADDIB, 8'h18, 3'b000, 1'b0};
        sweep[8]  = '{I_LW,    8'h19, 3'b000, 1'b0};
        sweep[9]  = '{I_SW,    8'h14, 3'b001, 1'b0};
        sweep[10] = '{I_LB,    8'h00, 3'b000, 1'b1};

        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        check("reset_e_ctrl", {24'h0, e_ctrl()}, 32'h0);
        check("reset_pcsrc", {31'h0, PCSrcE}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Decode sweep through the pipeline, no stalls or branches
        foreach (sweep[i]) begin
            drive(sweep[i].instr, 1'b0, 1'b0, 1'b0);
            check("sweep_immsrc", {29'h0, ImmSrcD}, {29'h0, sweep[i].exp_imm});
            check("sweep_illegal", {31'h0, IllegalD}, {31'h0, sweep[i].exp_ill});
            exp_q.push_back(sweep[i].exp_e);
            tick();
            check("sweep_e_ctrl", {24'h0, e_ctrl()}, {24'h0, exp_q.pop_front()});
            check("sweep_pcsrc", {31'h0, PCSrcE}, 32'h0);
        end

        // Branch taken: beq with Zero -> redirect, ID add is bubbled
        drive(I_BEQ, 1'b0, 1'b0, 1'b0);
        check("beq_immsrc", {29'h0, ImmSrcD}, 32'h2);
        tick();
        drive(I_ADD, 1'b0, 1'b0, 1'b1);
        check("beq_e_ctrl", {24'h0, e_ctrl()}, 32'h20);
        check("beq_pcsrc", {31'h0, PCSrcE}, 32'h1);
        check("beq_flushd", {31'h0, FlushD}, 32'h1);
        tick();
        check("beq_bubble", {24'h0, e_ctrl()}, 32'h0);
        check("beq_bubble_pcsrc", {31'h0, PCSrcE}, 32'h0);
        tick();
        check("after_bubble_add", {24'h0, e_ctrl()}, 32'h08);

        // Branch not taken: bne with Zero
        drive(I_BNE, 1'b0, 1'b0, 1'b0);
        tick();
        drive(I_ADD, 1'b0, 1'b0, 1'b1);
        check("bne_nt_pcsrc", {31'h0, PCSrcE}, 32'h0);
        check("bne_nt_flushd", {31'h0, FlushD}, 32'h0);
        ZeroE = 1'b0;
        #1;
        check("bne_t_pcsrc", {31'h0, PCSrcE}, 32'h1);
        ZeroE = 1'b1;
        #1;
        tick();
        check("bne_next_add", {24'h0, e_ctrl()}, 32'h08);

        // blt with !Zero taken; bge follows Zero with zero-cycle latency
        drive(I_BLT, 1'b0, 1'b0, 1'b0);
        tick();
        drive(I_BGE, 1'b0, 1'b0, 1'b0);
        check("blt_e_ctrl", {24'h0, e_ctrl()}, 32'h80);
        check("blt_pcsrc", {31'h0, PCSrcE}, 32'h1);
        tick();
        check("blt_bubble", {24'h0, e_ctrl()}, 32'h0);
        tick();
        drive(I_ADD, 1'b0, 1'b0, 1'b0);
        check("bge_e_ctrl", {24'h0, e_ctrl()}, 32'h80);
        check("bge_nt_pcsrc", {31'h0, PCSrcE}, 32'h0);
        ZeroE = 1'b1;
        #1;
        check("bge_t_pcsrc", {31'h0, PCSrcE}, 32'h1);
        ZeroE = 1'b0;

        // jal in EX overrides a simultaneous stall
        drive(I_JAL, 1'b0, 1'b0, 1'b0);
        check("jal_immsrc", {29'h0, ImmSrcD}, 32'h3);
        tick();
        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        check("jal_e_ctrl", {24'h0, e_ctrl()}, 32'h0A);
        check("jal_pcsrc", {31'h0, PCSrcE}, 32'h1);
        tick();
        check("jal_stall_bubble", {24'h0, e_ctrl()}, 32'h0);

        // Stall holds for 3 cycles, then stall+flush loads a bubble
        drive(I_XOR, 1'b0, 1'b0, 1'b0);
        tick();
        check("pre_stall_xor", {24'h0, e_ctrl()}, 32'hC8);
        drive(I_SUB, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {24'h0, e_ctrl()}, 32'hC8);
        end
        drive(I_SUB, 1'b1, 1'b1, 1'b0);
        tick();
        check("stall_flush_bubble", {24'h0, e_ctrl()}, 32'h0);
        drive(I_SUB, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_flush_sub", {24'h0, e_ctrl()}, 32'h28);

        // Illegal instruction
        drive(I_ILL, 1'b0, 1'b0, 1'b0);
        check("illegal_d", {31'h0, IllegalD}, 32'h1);
        tick();
        check("illegal_e_ctrl", {24'h0, e_ctrl()}, 32'h0);
        check("illegal_pcsrc", {31'h0, PCSrcE}, 32'h0);

        // Asynchronous reset mid-cycle with jal in EX
        drive(I_JAL, 1'b0, 1'b0, 1'b0);
        tick();
        drive(I_ADD, 1'b0, 1'b0, 1'b0);
        check("rst_jal_pcsrc_before", {31'h0, PCSrcE}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async_e_ctrl", {24'h0, e_ctrl()}, 32'h0);
        check("rst_async_pcsrc", {31'h0, PCSrcE}, 32'h0);
        check("rst_async_flushd", {31'h0, FlushD}, 32'h0);
        tick();
        check("rst_held_e_ctrl", {24'h0, e_ctrl()}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_release_load", {24'h0, e_ctrl()}, 32'h08);

        // ---------------------------------------------------------- report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
